// File: rtl/clock_ctrl_pkg.sv
// Shared mode encodings and default timing constants for the clock
// time-setting controller.
package clock_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_RUN      = 2'd0,
        MODE_SET_HOUR = 2'd1,
        MODE_SET_MIN  = 2'd2,
        MODE_SET_SEC  = 2'd3
    } mode_t;

    localparam int DEF_REPEAT_DELAY = 8;
    localparam int DEF_REPEAT_RATE  = 2;
    localparam int DEF_TIMEOUT_S    = 10;

    function automatic mode_t next_mode(input mode_t m);
        case (m)
            MODE_RUN:      return MODE_SET_HOUR;
            MODE_SET_HOUR: return MODE_SET_MIN;
            MODE_SET_MIN:  return MODE_SET_SEC;
            default:       return MODE_RUN;
        endcase
    endfunction

endpackage

// File: rtl/clock_set_ctrl_btn_edge.sv
// Button history register with rising-edge detect; history resets high
// so a button held through reset produces no edge.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);

    logic hist;

    always_ff @(posedge clk) begin
        if (rst) hist <= 1'b1;
        else     hist <= btn;
    end

    assign rise = btn & ~hist;

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-setting controller: mode sequencing, inc auto-repeat and inactivity
// timeout. Optional display blink: CLOCK_SET_CTRL_BLINK_EN.
import clock_ctrl_pkg::*;

module clock_set_ctrl #(
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEF_REPEAT_RATE,
    parameter int TIMEOUT_S    = DEF_TIMEOUT_S
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       tick_fast,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_clr,
    output logic       adjust_sec,
    output logic       adjust_min,
    output logic       adjust_hour,
    output logic       keep,
    output logic       clear,
    output logic [1:0] mode,
    output logic       blink
);

    localparam int RW  = $clog2(REPEAT_DELAY + 1);
    localparam int RRW = $clog2(REPEAT_RATE + 1);
    localparam int TW  = $clog2(TIMEOUT_S + 1);

    mode_t          state;
    logic [RW-1:0]  rep_cnt;
    logic [RRW-1:0] rate_cnt;
    logic [TW-1:0]  to_cnt;

    logic mode_e, inc_e, clr_e;
    logic in_set, strobe, delay_hit, rate_hit, fire, to_hit;

    btn_edge u_mode (.clk(clk), .rst(rst), .btn(btn_mode), .rise(mode_e));
    btn_edge u_inc  (.clk(clk), .rst(rst), .btn(btn_inc),  .rise(inc_e));
    btn_edge u_clr  (.clk(clk), .rst(rst), .btn(btn_clr),  .rise(clr_e));

    // rep_cnt parks at REPEAT_DELAY; rate_cnt then paces further pulses
    always_comb begin
        in_set    = (state != MODE_RUN);
        strobe    = in_set && btn_inc && tick_fast;
        delay_hit = strobe && (rep_cnt == RW'(REPEAT_DELAY - 1));
        rate_hit  = strobe && (rep_cnt == RW'(REPEAT_DELAY))
                    && (rate_cnt == RRW'(REPEAT_RATE - 1));
        fire      = in_set && (inc_e || delay_hit || rate_hit);
        to_hit    = in_set && tick_1hz && (to_cnt == TW'(TIMEOUT_S - 1));
    end

    always_ff @(posedge clk) begin
        adjust_sec  <= 1'b0;
        adjust_min  <= 1'b0;
        adjust_hour <= 1'b0;
        clear       <= 1'b0;
        if (rst) begin
            state    <= MODE_RUN;
            rep_cnt  <= '0;
            rate_cnt <= '0;
            to_cnt   <= '0;
        end else if (clr_e) begin
            clear    <= 1'b1;
            state    <= MODE_RUN;
            rep_cnt  <= '0;
            rate_cnt <= '0;
            to_cnt   <= '0;
        end else if (mode_e) begin
            state    <= next_mode(state);
            rep_cnt  <= '0;
            rate_cnt <= '0;
            to_cnt   <= '0;
        end else begin
            if (!in_set || !btn_inc) begin
                rep_cnt  <= '0;
                rate_cnt <= '0;
            end else if (strobe) begin
                if (rep_cnt != RW'(REPEAT_DELAY)) rep_cnt <= rep_cnt + 1'b1;
                else if (rate_hit)                rate_cnt <= '0;
                else                              rate_cnt <= rate_cnt + 1'b1;
            end
            if (fire) begin
                case (state)
                    MODE_SET_HOUR: adjust_hour <= 1'b1;
                    MODE_SET_MIN:  adjust_min  <= 1'b1;
                    MODE_SET_SEC:  adjust_sec  <= 1'b1;
                    default:       ;
                endcase
                to_cnt <= '0;
            end else if (to_hit) begin
                state    <= MODE_RUN;
                to_cnt   <= '0;
                rep_cnt  <= '0;
                rate_cnt <= '0;
            end else if (in_set && tick_1hz) begin
                to_cnt <= to_cnt + 1'b1;
            end else if (!in_set) begin
                to_cnt <= '0;
            end
        end
    end

    assign keep = (state != MODE_RUN);
    assign mode = state;

`ifdef CLOCK_SET_CTRL_BLINK_EN
    always_ff @(posedge clk) begin
        if (rst || state == MODE_RUN) blink <= 1'b0;
        else if (btn_inc)             blink <= 1'b1;
        else if (tick_fast)           blink <= ~blink;
    end
`else
    assign blink = 1'b0;
`endif

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Scoreboard bench for clock_set_ctrl: each driven cycle pushes the
// expected registered outputs, popped and compared on the next negedge.
module tb_clock_set_ctrl;
    import clock_ctrl_pkg::*;

    logic clk = 1'b0, rst = 1'b1;
    logic tick_1hz = 1'b0, tick_fast = 1'b0;
    logic btn_mode = 1'b0, btn_inc = 1'b0, btn_clr = 1'b0;
    logic adjust_sec, adjust_min, adjust_hour, keep, clear, blink;
    logic [1:0] mode;

    int vectors = 0;
    int miscompares = 0;
    int hour_pulses = 0;
    logic [7:0] sb[$];

    clock_set_ctrl dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_fast(tick_fast),
        .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_clr(btn_clr),
        .adjust_sec(adjust_sec), .adjust_min(adjust_min),
        .adjust_hour(adjust_hour), .keep(keep), .clear(clear),
        .mode(mode), .blink(blink)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", tag, got, want);
        end
    endtask

    // {adj_h, adj_m, adj_s, keep, clear, mode, blink}
    function automatic logic [7:0] ev(input logic h, input logic m,
                                      input logic s, input logic c,
                                      input logic [1:0] md);
        return {h, m, s, (md != 2'd0), c, md, 1'b0};
    endfunction

    function automatic logic [7:0] st(input logic [1:0] md);
        return ev(1'b0, 1'b0, 1'b0, 1'b0, md);
    endfunction

    function automatic logic [7:0] observed();
        logic b;
`ifdef CLOCK_SET_CTRL_BLINK_EN
        b = 1'b0;
`else
        b = blink;
`endif
        return {adjust_hour, adjust_min, adjust_sec, keep, clear, mode, b};
    endfunction

    task automatic cyc(input string tag, input logic md, input logic inc,
                       input logic cl, input logic t1, input logic tf,
                       input logic [7:0] e);
        logic [7:0] want;
        btn_mode  = md;
        btn_inc   = inc;
        btn_clr   = cl;
        tick_1hz  = t1;
        tick_fast = tf;
        sb.push_back(e);
        @(negedge clk);
        want = sb.pop_front();
        if (adjust_hour) hour_pulses++;
        check(tag, observed(), want);
    endtask

    initial begin
        logic p;
        rst = 1'b1;
        btn_mode = 1'b1;
        @(negedge clk);
        cyc("rst", 1, 0, 0, 0, 0, st(0));
        cyc("rst", 1, 0, 0, 0, 0, st(0));
        rst = 1'b0;
        cyc("hold_mode", 1, 0, 0, 0, 0, st(0));
        cyc("hold_mode", 1, 0, 0, 0, 0, st(0));
        cyc("rel_mode", 0, 0, 0, 0, 0, st(0));

        for (int i = 1; i <= 4; i++) begin
            cyc("mode_step", 1, 0, 0, 0, 0, st(2'(i)));
            cyc("mode_hold", 0, 0, 0, 0, 0, st(2'(i)));
        end

        cyc("to_hour", 1, 0, 0, 0, 0, st(1));
        cyc("to_hour", 0, 0, 0, 0, 0, st(1));
        cyc("to_min", 1, 0, 0, 0, 0, st(2));
        cyc("to_min", 0, 0, 0, 0, 0, st(2));
        cyc("inc_min", 0, 1, 0, 0, 0, ev(0, 1, 0, 0, 2));
        cyc("inc_min_hold", 0, 1, 0, 0, 0, st(2));
        cyc("inc_min_rel", 0, 0, 0, 0, 0, st(2));

        cyc("clr_mode", 1, 1, 1, 0, 0, ev(0, 0, 0, 1, 0));
        cyc("clr_after", 0, 0, 0, 0, 0, st(0));

        cyc("to_hour", 1, 0, 0, 0, 0, st(1));
        cyc("to_hour", 0, 0, 0, 0, 0, st(1));
        hour_pulses = 0;
        cyc("inc_hour", 0, 1, 0, 0, 0, ev(1, 0, 0, 0, 1));
        for (int k = 1; k <= 14; k++) begin
            p = (k >= 8) && ((k - 8) % 2 == 0);
            cyc("rep_strobe", 0, 1, 0, 0, 1, ev(p, 0, 0, 0, 1));
            cyc("rep_gap", 0, 1, 0, 0, 0, st(1));
        end
        cyc("rep_rel", 0, 0, 0, 0, 0, st(1));
        check("rep_total", 8'(hour_pulses), 8'd5);

        cyc("to_min", 1, 0, 0, 0, 0, st(2));
        cyc("to_min", 0, 0, 0, 0, 0, st(2));
        cyc("to_sec", 1, 0, 0, 0, 0, st(3));
        cyc("to_sec", 0, 0, 0, 0, 0, st(3));
        for (int k = 1; k <= 10; k++) begin
            cyc("timeout_tick", 0, 0, 0, 1, 0, st(k == 10 ? 2'd0 : 2'd3));
            cyc("timeout_idle", 0, 0, 0, 0, 0, st(k == 10 ? 2'd0 : 2'd3));
        end

        cyc("run_inc", 0, 1, 0, 0, 0, st(0));
        cyc("run_inc", 0, 1, 0, 0, 1, st(0));
        cyc("run_rel", 0, 0, 0, 0, 0, st(0));

        cyc("to_hour", 1, 0, 0, 0, 0, st(1));
        cyc("to_hour", 0, 0, 0, 0, 0, st(1));
        for (int k = 1; k <= 9; k++)
            cyc("pre_tick", 0, 0, 0, 1, 0, st(1));
        cyc("inc_rearm", 0, 1, 0, 0, 0, ev(1, 0, 0, 0, 1));
        cyc("inc_rel", 0, 0, 0, 0, 0, st(1));
        for (int k = 1; k <= 10; k++)
            cyc("post_tick", 0, 0, 0, 1, 0, st(k == 10 ? 2'd0 : 2'd1));
        cyc("post_idle", 0, 0, 0, 0, 0, st(0));

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
